// File: rtl/bf_pkg.sv
// Shared definitions for the IF/ID buffer: instruction field positions, logical-immediate
// opcodes, the decoded-field bundle and the immediate-extension helpers.
package bf_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JA_MSB  = 25;
  localparam int JA_LSB  = 0;

  localparam logic [5:0] ANDI = 6'h0C;
  localparam logic [5:0] ORI  = 6'h0D;
  localparam logic [5:0] XORI = 6'h0E;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [25:0] jaddr;
  } bf_fields_t;

  function automatic logic [31:0] imm_ext(input logic [15:0] imm, input logic sign_en);
    if (sign_en) begin
      imm_ext = {{16{imm[15]}}, imm};
    end else begin
      imm_ext = {16'h0000, imm};
    end
  endfunction

  // Logical immediates always zero-extend, whatever the build.
  function automatic logic is_logic_imm(input logic [5:0] op);
    case (op)
      ANDI, ORI, XORI: is_logic_imm = 1'b1;
      default:         is_logic_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bf_ifid_if.sv
// Fetch-side and decode-side handshake plus decoded-field bus of the IF/ID buffer.
interface bf_ifid_if #(parameter int PC_W = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [PC_W-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opBF;
  logic [5:0]      functBF;
  logic [4:0]      rsBF;
  logic [4:0]      rtBF;
  logic [4:0]      rdBF;
  logic [4:0]      shamtBF;
  logic [31:0]     immBF;
  logic [25:0]     jaddrBF;
  logic [PC_W-1:0] pc_out;

  modport master (
    output in_valid, instr_in, pc_in, out_ready,
    input  in_ready, out_valid, opBF, functBF, rsBF, rtBF, rdBF, shamtBF, immBF, jaddrBF, pc_out
  );

  modport slave (
    input  in_valid, instr_in, pc_in, out_ready,
    output in_ready, out_valid, opBF, functBF, rsBF, rtBF, rdBF, shamtBF, immBF, jaddrBF, pc_out
  );
endinterface

// File: rtl/bf_decode.sv
// Combinational MIPS field split and immediate extension.
// Define BF_IFID_SIGNEXT_EN to sign-extend arithmetic immediates; default is zero-extension.
module bf_decode
  import bf_pkg::*;
(
  input  logic [31:0] instr_i,
  output bf_fields_t  fields_o
);

  logic sign_en_s;

  always_comb begin
    fields_o       = '0;
    fields_o.op    = instr_i[OP_MSB:OP_LSB];
    fields_o.rs    = instr_i[RS_MSB:RS_LSB];
    fields_o.rt    = instr_i[RT_MSB:RT_LSB];
    fields_o.rd    = instr_i[RD_MSB:RD_LSB];
    fields_o.shamt = instr_i[SH_MSB:SH_LSB];
    fields_o.funct = instr_i[FN_MSB:FN_LSB];
    fields_o.jaddr = instr_i[JA_MSB:JA_LSB];
`ifdef BF_IFID_SIGNEXT_EN
    sign_en_s      = ~is_logic_imm(instr_i[OP_MSB:OP_LSB]);
`else
    sign_en_s      = 1'b0;
`endif
    fields_o.imm   = imm_ext(instr_i[IMM_MSB:IMM_LSB], sign_en_s);
  end

endmodule

// File: rtl/bf_ifid.sv
// IF/ID pipeline buffer: registered main entry feeding decode plus a skid entry, so that
// in_ready depends only on state. Optional build macro: BF_IFID_SIGNEXT_EN (see bf_decode).
module bf_ifid
  import bf_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic     clk_bf_ifid,
  input  logic     rst_bf_ifid,
  input  logic     flush_bf_ifid,
  bf_ifid_if.slave bus
);

  typedef struct packed {
    bf_fields_t      f;
    logic [PC_W-1:0] pc;
  } entry_t;

  bf_fields_t dec_s;
  entry_t     new_s;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       xfer_in_s;
  logic       xfer_out_s;

  // Decoding ahead of both entries keeps a single decoder and registered outputs.
  bf_decode u_decode (
    .instr_i  (bus.instr_in),
    .fields_o (dec_s)
  );

  assign new_s      = '{f: dec_s, pc: bus.pc_in};
  assign xfer_in_s  = bus.in_valid & ~skid_valid_q;
  assign xfer_out_s = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_bf_ifid) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (xfer_out_s) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (xfer_in_s) begin
        main_d       = new_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (xfer_in_s) begin
      // Main stalled: park the new word in the skid entry.
      if (main_valid_q) begin
        skid_d       = new_s;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = new_s;
        main_valid_d = 1'b1;
      end
    end else begin
      main_d = main_q;
    end
  end

  always_ff @(posedge clk_bf_ifid or posedge rst_bf_ifid) begin
    if (rst_bf_ifid) begin
      main_q       <= '{f: '0, pc: RESET_PC};
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = ~skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign bus.opBF      = main_q.f.op;
  assign bus.rsBF      = main_q.f.rs;
  assign bus.rtBF      = main_q.f.rt;
  assign bus.rdBF      = main_q.f.rd;
  assign bus.shamtBF   = main_q.f.shamt;
  assign bus.functBF   = main_q.f.funct;
  assign bus.immBF     = main_q.f.imm;
  assign bus.jaddrBF   = main_q.f.jaddr;
  assign bus.pc_out    = main_q.pc;

endmodule

// File: tb/tb_bf_ifid.sv
// Self-checking bench for bf_ifid: directed scenarios plus random traffic against a
// queue-based reference of the two-entry buffer.
module tb_bf_ifid;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  flush;
  int    n_checks = 0;
  int    n_fail   = 0;
  item_t mq[$];
  item_t shown;
  logic  last_acc;

  bf_ifid_if #(.PC_W(PC_W)) bus ();

  bf_ifid #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk_bf_ifid   (clk),
    .rst_bf_ifid   (rst),
    .flush_bf_ifid (flush),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_imm(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
`ifdef BF_IFID_SIGNEXT_EN
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, w[15:0]};
    else return {{16{w[15]}}, w[15:0]};
`else
    return {16'h0000, w[15:0]};
`endif
  endfunction

  // The presented word is the queue head; with an empty queue the last one shown persists.
  task automatic compare_all(input string ctx);
    logic [31:0] w;
    w = shown.instr;
    check_eq({ctx, ".out_valid"}, bus.out_valid, mq.size() > 0);
    check_eq({ctx, ".in_ready"}, bus.in_ready, mq.size() < 2);
    check_eq({ctx, ".op"}, bus.opBF, w[31:26]);
    check_eq({ctx, ".rs"}, bus.rsBF, w[25:21]);
    check_eq({ctx, ".rt"}, bus.rtBF, w[20:16]);
    check_eq({ctx, ".rd"}, bus.rdBF, w[15:11]);
    check_eq({ctx, ".shamt"}, bus.shamtBF, w[10:6]);
    check_eq({ctx, ".funct"}, bus.functBF, w[5:0]);
    check_eq({ctx, ".imm"}, bus.immBF, exp_imm(w));
    check_eq({ctx, ".jaddr"}, bus.jaddrBF, w[25:0]);
    check_eq({ctx, ".pc"}, bus.pc_out, shown.pc);
  endtask

  task automatic model_reset();
    mq.delete();
    shown = '{instr: 32'h0, pc: RESET_PC};
  endtask

  // Called at a falling edge: drive, advance one clock, update the model, compare.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input string ctx);
    logic acc;
    bus.in_valid  = v;
    bus.instr_in  = ins;
    bus.pc_in     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    acc = v && (mq.size() < 2);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc) mq.push_back('{instr: ins, pc: pc});
    end
    if (mq.size() > 0) shown = mq[0];
    last_acc = acc && !fl;
    @(negedge clk);
    compare_all(ctx);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr_in = 32'h0;
    bus.pc_in = 32'h0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Streaming: add $8,$9,$10 then 8 back-to-back words.
    cycle(1'b1, 32'h012A_4020, 32'h0000_1004, 1'b1, 1'b0, "stream0");
    check_eq("stream.op", bus.opBF, 6'd0);
    check_eq("stream.rs", bus.rsBF, 5'd9);
    check_eq("stream.rt", bus.rtBF, 5'd10);
    check_eq("stream.rd", bus.rdBF, 5'd8);
    check_eq("stream.funct", bus.functBF, 6'h20);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, $urandom, 32'h0000_2000 + 32'(4 * i), 1'b1, 1'b0, "stream");
      check_eq("stream.acc", last_acc, 1'b1);
    end
    drain();

    // Backpressure: three words offered while stalled.
    cycle(1'b1, 32'h2001_0001, 32'h0000_3004, 1'b0, 1'b0, "bp1");
    cycle(1'b1, 32'h2002_0002, 32'h0000_3008, 1'b0, 1'b0, "bp2");
    check_eq("bp.in_ready_full", bus.in_ready, 1'b0);
    cycle(1'b1, 32'h2003_0003, 32'h0000_300C, 1'b0, 1'b0, "bp3");
    check_eq("bp.c_rejected", last_acc, 1'b0);
    check_eq("bp.frozen_pc", bus.pc_out, 32'h0000_3004);
    cycle(1'b1, 32'h2003_0003, 32'h0000_300C, 1'b1, 1'b0, "bp_rel");
    check_eq("bp.second_pc", bus.pc_out, 32'h0000_3008);
    last_acc = 1'b0;
    for (int k = 0; k < 8 && !last_acc; k++)
      cycle(1'b1, 32'h2003_0003, 32'h0000_300C, 1'b1, 1'b0, "bp_c");
    check_eq("bp.c_accepted", last_acc, 1'b1);
    check_eq("bp.third_pc", bus.pc_out, 32'h0000_300C);
    drain();

    // Flush with both entries full and a word offered.
    cycle(1'b1, 32'h2004_0004, 32'h0000_4004, 1'b0, 1'b0, "fl1");
    cycle(1'b1, 32'h2005_0005, 32'h0000_4008, 1'b0, 1'b0, "fl2");
    cycle(1'b1, 32'h2006_0006, 32'h0000_400C, 1'b1, 1'b1, "flush");
    check_eq("flush.out_valid", bus.out_valid, 1'b0);
    check_eq("flush.in_ready", bus.in_ready, 1'b1);
    drain();

    // Immediate extension.
    cycle(1'b1, 32'h2108_FFFF, 32'h0000_5004, 1'b1, 1'b0, "addi");
`ifdef BF_IFID_SIGNEXT_EN
    check_eq("imm.addi", bus.immBF, 32'hFFFF_FFFF);
`else
    check_eq("imm.addi", bus.immBF, 32'h0000_FFFF);
`endif
    cycle(1'b1, 32'h3508_FFFF, 32'h0000_5008, 1'b1, 1'b0, "ori");
    check_eq("imm.ori", bus.immBF, 32'h0000_FFFF);
    drain();

    // Simultaneous consume and accept with skid empty.
    cycle(1'b1, 32'h2007_0007, 32'h0000_6004, 1'b0, 1'b0, "sim1");
    cycle(1'b1, 32'h2008_0008, 32'h0000_6008, 1'b1, 1'b0, "sim2");
    check_eq("sim.in_ready", bus.in_ready, 1'b1);
    check_eq("sim.out_valid", bus.out_valid, 1'b1);
    check_eq("sim.pc", bus.pc_out, 32'h0000_6008);

    // Asynchronous reset with a word in main, checked before any clock edge.
    cycle(1'b1, 32'h2009_0009, 32'h0000_7004, 1'b0, 1'b0, "rst_pre");
    #2 rst = 1'b1;
    #1;
    check_eq("arst.out_valid", bus.out_valid, 1'b0);
    check_eq("arst.in_ready", bus.in_ready, 1'b1);
    check_eq("arst.pc", bus.pc_out, RESET_PC);
    check_eq("arst.op", bus.opBF, 6'd0);
    check_eq("arst.imm", bus.immBF, 32'd0);
    check_eq("arst.jaddr", bus.jaddrBF, 26'd0);
    model_reset();
    @(negedge clk);
    compare_all("arst");
    rst = 1'b0;
    cycle(1'b1, 32'h200A_000A, 32'h0000_8004, 1'b1, 1'b0, "post_rst");
    check_eq("post_rst.pc", bus.pc_out, 32'h0000_8004);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[31:26] = 6'(6'h0C + $urandom_range(0, 2));
      cycle($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_ifid.md
BF_IFID -- requirements
Module: bf_ifid

Interface
REQ-001 Parameter PC_W, default 32: width of the program-counter pass-through field.
REQ-002 Parameter RESET_PC, default 0: value loaded into pc_out on reset.
REQ-003 clk_bf_ifid  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_bf_ifid  input  1  asynchronous, active-high reset.
REQ-005 flush_bf_ifid  input  1  synchronous pipeline flush (branch/jump taken).
REQ-006 in_valid, in_ready  input/output  1 each  upstream (fetch) handshake.
REQ-007 instr_in  input  32  fetched MIPS instruction word.
REQ-008 pc_in  input  PC_W  PC+4 of the fetched instruction.
REQ-009 out_valid, out_ready  output/input  1 each  downstream (decode) handshake.
REQ-010 opBF, functBF  output  6 each  instr[31:26], instr[5:0].
REQ-011 rsBF, rtBF, rdBF, shamtBF  output  5 each  instr[25:21], [20:16], [15:11], [10:6].
REQ-012 immBF  output  32  extended instr[15:0]; jaddrBF  output  26  instr[25:0].
REQ-013 pc_out  output  PC_W  PC field of the presented instruction.

Function
REQ-014 The block SHALL be a two-entry buffer: a main register driving all outputs, plus a skid register.
REQ-015 A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-016 in_ready SHALL equal !skid_valid, driven from a register, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal main_valid.
REQ-018 Latency: an instruction accepted while both entries are empty appears on outputs with out_valid=1 on the next cycle.
REQ-019 If main is empty, or is consumed in the same cycle, an incoming word SHALL load main. Throughput is one instruction per cycle with no bubbles.
REQ-020 If main holds a word that is not consumed, an incoming word SHALL load the skid register.
REQ-021 On a transfer out with skid valid, skid SHALL move to main. A word accepted in that same cycle is impossible, because in_ready=0.
REQ-022 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-023 flush_bf_ifid=1 SHALL clear main_valid and skid_valid on the next edge and discard any word accepted that cycle. Flush overrides every simultaneous transfer.
REQ-024 Field outputs and pc_out SHALL retain their last values when main_valid=0.
REQ-025 Field decoding SHALL be registered, with no combinational path from instr_in to the outputs.
REQ-026 pc_out SHALL be truncated or zero-extended to PC_W from pc_in, never sign-extended.

Reset
REQ-027 On rst_bf_ifid=1, the block SHALL immediately clear main_valid and skid_valid, set every field output to 0, set pc_out to RESET_PC, and set in_ready to 1.
REQ-028 Reset asserted mid-transfer SHALL lose both buffered words with no partial update. The first accept after deassertion behaves as from empty.

Configuration
REQ-029 With macro BF_IFID_SIGNEXT_EN defined, immBF SHALL be sign-extended from instr[15], except for op 0x0C/0x0D/0x0E (andi/ori/xori), which are zero-extended.
REQ-030 Without BF_IFID_SIGNEXT_EN, immBF SHALL always be zero-extended. Port list and timing SHALL be identical in both builds.

Structure
REQ-031 A shared package bf_pkg SHALL hold the field bit-position constants, the opcode constants ANDI/ORI/XORI, and a typedef for the decoded-field bundle.
REQ-032 A sub-module bf_decode (combinational field split plus immediate extension) SHALL be instantiated twice, once for the main path and once for the skid path, or once ahead of both registers.

Verification
REQ-033 Reset: assert rst mid-cycle with a word in main -> out_valid=0, pc_out=RESET_PC, and all fields 0 immediately, without waiting for a clock edge.
REQ-034 Streaming: instr 0x012A4020 (add $8,$9,$10), out_ready=1 -> next cycle op=0, rs=9, rt=10, rd=8, funct=0x20. Then one instruction per cycle for 8 back-to-back words, none dropped.
REQ-035 Backpressure: hold out_ready=0, send 3 words -> 2 accepted, in_ready=0 after the second, outputs frozen on word 1. Release -> words 1, 2, 3 emerge in order.
REQ-036 Flush: flush=1 with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and neither buffered word nor the incoming word is ever presented.
REQ-037 Immediate: instr 0x2108FFFF (addi) -> immBF=0xFFFFFFFF with the macro, 0x0000FFFF without. Instr 0x3508FFFF (ori) -> 0x0000FFFF in both builds.
REQ-038 Simultaneous: main full, skid empty, out_ready=1 and in_valid=1 in the same cycle -> new word goes directly to main, skid stays empty, in_ready stays 1.
